mem_access_unit: RTL and testbench

// Request-side front end of the unified instruction/data memory of the multicycle MIPS core.

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: request kinds, access sizes, FSM states.
package mem_access_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_RSVD  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RMW_WR = 2'd2;

    // FETCH is always a full word; any other kind with byte/half size needs lane handling.
    function automatic logic is_sub_word(input logic [1:0] kind, input logic [1:0] size);
        return (kind != KIND_FETCH) && ((size == SZ_BYTE) || (size == SZ_HALF));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request bus from the control FSM plus the unified memory port of the multicycle core.
interface mem_access_unit_if;
    logic        Req;
    logic [1:0]  Kind;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ByteAddr;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic [31:0] Instr;
    logic [31:0] LoadData;
    logic        Fault;
    logic [31:0] FaultAddr;
    logic [31:0] MemAddr;
    logic        MemWe;
    logic [31:0] MemWd;
    logic [31:0] MemRd;

    modport master (
        output Req, Kind, Size, Unsigned, ByteAddr, StoreData, MemRd,
        input  Busy, Done, Instr, LoadData, Fault, FaultAddr, MemAddr, MemWe, MemWd
    );

    modport slave (
        input  Req, Kind, Size, Unsigned, ByteAddr, StoreData, MemRd,
        output Busy, Done, Instr, LoadData, Fault, FaultAddr, MemAddr, MemWe, MemWd
    );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte/half lane extraction with sign/zero extension, and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_rd,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = 8'h00;
        case (addr_lo)
            2'd0: lane_byte = mem_rd[31:24];
            2'd1: lane_byte = mem_rd[23:16];
            2'd2: lane_byte = mem_rd[15:8];
            2'd3: lane_byte = mem_rd[7:0];
        endcase
        lane_half = addr_lo[1] ? mem_rd[15:0] : mem_rd[31:16];
    end

    always_comb begin
        load_data = mem_rd;
        merged    = store_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{lane_byte[7] & ~is_unsigned}}, lane_byte};
                merged    = mem_rd;
                case (addr_lo)
                    2'd0: merged[31:24] = store_data[7:0];
                    2'd1: merged[23:16] = store_data[7:0];
                    2'd2: merged[15:8]  = store_data[7:0];
                    2'd3: merged[7:0]   = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = {{16{lane_half[15] & ~is_unsigned}}, lane_half};
                merged    = mem_rd;
                if (addr_lo[1]) begin
                    merged[15:0] = store_data[15:0];
                end else begin
                    merged[31:16] = store_data[15:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Request-side front end of the unified instruction/data memory: fetch, load, store with
// sub-word read-modify-write, alignment/range faults, and the Instr/LoadData registers.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for Req; Done/Fault pulses appear here
//   ST_ACCESS | memory addressed; fetch/load captured, word store written
//   ST_RMW_WR | merged word written back for a byte/half store
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    mem_access_unit_if.slave  bus
);

    logic [1:0]  state_q,  state_d;
    logic [1:0]  kind_q,   kind_d;
    logic [1:0]  size_q,   size_d;
    logic        uns_q,    uns_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] idx_q,    idx_d;
    logic [31:0] sdata_q,  sdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] load_q,   load_d;
    logic [31:0] faddr_q,  faddr_d;
    logic        done_q,   done_d;
    logic        fault_q,  fault_d;

    logic [31:0] req_idx;
    logic        req_wordlike;
    logic        req_fault;
    logic        sub_store;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    mem_lane_align u_lane_align (
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .mem_rd      (bus.MemRd),
        .store_data  (sdata_q),
        .load_data   (lane_load),
        .merged      (lane_merged)
    );

    always_comb begin
        req_idx      = {2'b00, bus.ByteAddr[31:2]};
        req_wordlike = !is_sub_word(bus.Kind, bus.Size);
        req_fault    = (bus.Kind == KIND_RSVD)
                    || (req_idx >= DEPTH)
                    || (req_wordlike && (bus.ByteAddr[1:0] != 2'b00))
                    || (!req_wordlike && (bus.Size == SZ_HALF) && bus.ByteAddr[0]);
        sub_store    = (kind_q == KIND_STORE) && is_sub_word(kind_q, size_q);
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_lo_d = addr_lo_q;
        idx_d     = idx_q;
        sdata_d   = sdata_q;
        merged_d  = merged_q;
        instr_d   = instr_q;
        load_d    = load_q;
        faddr_d   = faddr_q;
        done_d    = 1'b0;
        fault_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Req) begin
                    if (req_fault) begin
                        fault_d = 1'b1;
                        faddr_d = bus.ByteAddr;
                    end else begin
                        state_d   = ST_ACCESS;
                        kind_d    = bus.Kind;
                        size_d    = bus.Size;
                        uns_d     = bus.Unsigned;
                        addr_lo_d = bus.ByteAddr[1:0];
                        idx_d     = req_idx;
                        sdata_d   = bus.StoreData;
                    end
                end
            end
            ST_ACCESS: begin
                if (kind_q == KIND_FETCH) begin
                    instr_d = bus.MemRd;
                end
                if (kind_q == KIND_LOAD) begin
                    load_d = lane_load;
                end
                if (sub_store) begin
                    merged_d = lane_merged;
                    state_d  = ST_RMW_WR;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_RMW_WR: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_lo_q <= 2'b00;
            idx_q     <= 32'h0;
            sdata_q   <= 32'h0;
            merged_q  <= 32'h0;
            instr_q   <= RESET_INSTR;
            load_q    <= 32'h0;
            faddr_q   <= 32'h0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_lo_q <= addr_lo_d;
            idx_q     <= idx_d;
            sdata_q   <= sdata_d;
            merged_q  <= merged_d;
            instr_q   <= instr_d;
            load_q    <= load_d;
            faddr_q   <= faddr_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    // Write strobe decodes straight from state so an async reset kills it mid-write.
    always_comb begin
        bus.MemWe = 1'b0;
        bus.MemWd = 32'h0;
        if (state_q == ST_RMW_WR) begin
            bus.MemWe = 1'b1;
            bus.MemWd = merged_q;
        end else if ((state_q == ST_ACCESS) && (kind_q == KIND_STORE) && !sub_store) begin
            bus.MemWe = 1'b1;
            bus.MemWd = sdata_q;
        end
    end

    assign bus.MemAddr   = idx_q;
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Done      = done_q;
    assign bus.Fault     = fault_q;
    assign bus.Instr     = instr_q;
    assign bus.LoadData  = load_q;
    assign bus.FaultAddr = faddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner sequences, and
// random requests checked against an arithmetic reference model with a shadow memory.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam logic [31:0] RST_INSTR = 32'h0BAD_F00D;

    logic Clk;
    logic Rst_n;
    mem_access_unit_if bus ();

    mem_access_unit #(
        .DEPTH       (64),
        .RESET_INSTR (RST_INSTR)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;

    always @(posedge Clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (bus.MemWe && (bus.MemAddr < 32'd64)) mem[bus.MemAddr[5:0]] <= bus.MemWd;
    end
    assign bus.MemRd = (bus.MemAddr < 32'd64) ? mem[bus.MemAddr[5:0]] : 32'h0;

    logic both_seen = 1'b0;
    logic we_idle_seen = 1'b0;
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (bus.Done && bus.Fault) both_seen = 1'b1;
            if (bus.MemWe && !bus.Busy) we_idle_seen = 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic preload(input int unsigned idx, input logic [31:0] val);
        @(negedge Clk);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = val;
        @(posedge Clk);
        #1;
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // lat counts cycles from the Req cycle to the Done/Fault cycle; 0 means timeout.
    task automatic do_req(input logic [1:0] k, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic got_fault, output logic we_any,
                          output logic we0, output logic we1, output logic [31:0] addr0);
        @(negedge Clk);
        bus.Req       = 1'b1;
        bus.Kind      = k;
        bus.Size      = s;
        bus.Unsigned  = u;
        bus.ByteAddr  = a;
        bus.StoreData = d;
        @(posedge Clk);
        #1;
        bus.Req   = 1'b0;
        lat       = 0;
        got_fault = bus.Fault;
        we_any    = bus.MemWe;
        we0       = bus.MemWe;
        we1       = 1'b0;
        addr0     = bus.MemAddr;
        if (bus.Fault) begin
            lat = 1;
        end else begin
            for (int c = 2; c <= 8; c++) begin
                @(posedge Clk);
                #1;
                if (c == 2) we1 = bus.MemWe;
                if (bus.MemWe) we_any = 1'b1;
                if (bus.Fault) got_fault = 1'b1;
                if (bus.Done || bus.Fault) begin
                    lat = c;
                    break;
                end
            end
        end
    endtask

    logic [31:0] exp_instr, exp_load, exp_faddr;

    // Reference model: lanes expressed as a shift/mask over the big-endian word.
    task automatic model_req(input logic [1:0] k, input logic [1:0] s, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic f, output int lat);
        int unsigned nb, sh, idx;
        logic [31:0] mask, w, v;
        logic wordlike;
        wordlike = (k == KIND_FETCH) || (s == SZ_WORD);
        idx = a >> 2;
        f = (k == KIND_RSVD) || (idx >= 64) || (wordlike && (a % 4 != 0))
            || (!wordlike && (s == SZ_HALF) && a[0]);
        lat = 1;
        if (f) begin
            exp_faddr = a;
        end else begin
            nb   = wordlike ? 4 : ((s == SZ_HALF) ? 2 : 1);
            sh   = (4 - (a % 4) - nb) * 8;
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            w    = ref_mem[idx];
            lat  = 2;
            if (k == KIND_FETCH) begin
                exp_instr = w;
            end else if (k == KIND_LOAD) begin
                v = (w >> sh) & mask;
                if (!u && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
                exp_load = v;
            end else begin
                ref_mem[idx] = (w & ~(mask << sh)) | ((d & mask) << sh);
                if (nb < 4) lat = 3;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] pre;
        logic        exp_fault;
        int          exp_lat;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [15];

    int          lat;
    logic        gf, wa, w0, w1, ef;
    logic [31:0] a0;
    int          el;

    initial begin
        Rst_n         = 1'b0;
        bus.Req       = 1'b0;
        bus.Kind      = 2'd0;
        bus.Size      = 2'd0;
        bus.Unsigned  = 1'b0;
        bus.ByteAddr  = 32'h0;
        bus.StoreData = 32'h0;

        vecs[0]  = '{KIND_FETCH, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0,         32'h2010_0005, 1'b0, 2, 32'h2010_0005};
        vecs[1]  = '{KIND_LOAD,  SZ_BYTE, 1'b0, 32'h0000_0005, 32'h0,         32'h12F4_5678, 1'b0, 2, 32'hFFFF_FFF4};
        vecs[2]  = '{KIND_LOAD,  SZ_BYTE, 1'b1, 32'h0000_0005, 32'h0,         32'h12F4_5678, 1'b0, 2, 32'h0000_00F4};
        vecs[3]  = '{KIND_STORE, SZ_HALF, 1'b0, 32'h0000_000E, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 3, 32'h1122_BEEF};
        vecs[4]  = '{KIND_STORE, SZ_WORD, 1'b0, 32'h0000_0006, 32'h5555_AAAA, 32'h0102_0304, 1'b1, 1, 32'h0};
        vecs[5]  = '{KIND_STORE, SZ_WORD, 1'b0, 32'h0000_0100, 32'h5555_AAAA, 32'h0,         1'b1, 1, 32'h0};
        vecs[6]  = '{KIND_LOAD,  SZ_HALF, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_8001, 1'b0, 2, 32'hFFFF_8001};
        vecs[7]  = '{KIND_LOAD,  SZ_HALF, 1'b1, 32'h0000_0010, 32'h0,         32'h8001_0000, 1'b0, 2, 32'h0000_8001};
        vecs[8]  = '{KIND_STORE, SZ_BYTE, 1'b0, 32'h0000_001B, 32'hFFFF_FFAB, 32'h1122_3344, 1'b0, 3, 32'h1122_33AB};
        vecs[9]  = '{KIND_LOAD,  SZ_HALF, 1'b0, 32'h0000_0003, 32'h0,         32'h7777_7777, 1'b1, 1, 32'h0};
        vecs[10] = '{KIND_RSVD,  SZ_WORD, 1'b0, 32'h0000_0030, 32'h0,         32'h6666_6666, 1'b1, 1, 32'h0};
        vecs[11] = '{KIND_FETCH, SZ_BYTE, 1'b0, 32'h0000_00FC, 32'h0,         32'h8C42_0010, 1'b0, 2, 32'h8C42_0010};
        vecs[12] = '{KIND_LOAD,  SZ_WORD, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_BABE, 1'b0, 2, 32'hCAFE_BABE};
        vecs[13] = '{KIND_STORE, SZ_WORD, 1'b0, 32'h0000_0024, 32'h0123_4567, 32'hFFFF_FFFF, 1'b0, 2, 32'h0123_4567};
        vecs[14] = '{KIND_FETCH, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0,         32'h4444_4444, 1'b1, 1, 32'h0};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_busy",   32'(bus.Busy),  32'h0);
        chk("rst_done",   32'(bus.Done),  32'h0);
        chk("rst_fault",  32'(bus.Fault), 32'h0);
        chk("rst_we",     32'(bus.MemWe), 32'h0);
        chk("rst_wd",     bus.MemWd,      32'h0);
        chk("rst_maddr",  bus.MemAddr,    32'h0);
        chk("rst_instr",  bus.Instr,      RST_INSTR);
        chk("rst_load",   bus.LoadData,   32'h0);
        chk("rst_faddr",  bus.FaultAddr,  32'h0);

        for (int i = 0; i < 15; i++) begin
            vec_t v;
            logic in_rng;
            v = vecs[i];
            in_rng = (v.addr >> 2) < 32'd64;
            if (in_rng) preload(v.addr >> 2, v.pre);
            do_req(v.kind, v.size, v.uns, v.addr, v.sdata, lat, gf, wa, w0, w1, a0);
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'(v.exp_lat));
            chk($sformatf("v%0d_fault", i), 32'(gf),  32'(v.exp_fault));
            if (v.exp_fault) begin
                chk($sformatf("v%0d_faddr", i), bus.FaultAddr, v.addr);
                chk($sformatf("v%0d_we_any", i), 32'(wa), 32'h0);
                if (in_rng) chk($sformatf("v%0d_mem_kept", i), mem[v.addr[7:2]], v.pre);
            end else begin
                chk($sformatf("v%0d_maddr", i), a0, v.addr >> 2);
                if (v.kind == KIND_FETCH) chk($sformatf("v%0d_instr", i), bus.Instr, v.exp_val);
                else if (v.kind == KIND_LOAD) chk($sformatf("v%0d_load", i), bus.LoadData, v.exp_val);
                else chk($sformatf("v%0d_mem", i), mem[v.addr[7:2]], v.exp_val);
                if (v.exp_lat == 3) begin
                    chk($sformatf("v%0d_we_access", i), 32'(w0), 32'h0);
                    chk($sformatf("v%0d_we_rmw", i),    32'(w1), 32'h1);
                end
            end
        end

        // Back-to-back: Req held high across the Done cycle of the fetch.
        begin
            int d1, d2;
            preload(0, 32'h3C01_1234);
            preload(1, 32'h89AB_CDEF);
            d1 = -1;
            d2 = -1;
            @(negedge Clk);
            bus.Req      = 1'b1;
            bus.Kind     = KIND_FETCH;
            bus.Size     = SZ_WORD;
            bus.Unsigned = 1'b0;
            bus.ByteAddr = 32'h0;
            @(posedge Clk);
            #1;
            bus.Kind     = KIND_LOAD;
            bus.ByteAddr = 32'h4;
            for (int c = 1; c <= 6; c++) begin
                @(posedge Clk);
                #1;
                if (bus.Done) begin
                    if (d1 < 0) begin
                        d1 = c;
                        chk("b2b_instr", bus.Instr, 32'h3C01_1234);
                    end else if (d2 < 0) begin
                        d2 = c;
                        chk("b2b_load", bus.LoadData, 32'h89AB_CDEF);
                    end
                end
                if (d1 > 0 && c == d1 + 1) bus.Req = 1'b0;
            end
            bus.Req = 1'b0;
            chk("b2b_first_done", 32'(d1), 32'd1);
            chk("b2b_gap",        32'(d2 - d1), 32'd2);
        end

        // Reset asserted while the merged word is being written back.
        preload(7, 32'h5566_7788);
        @(negedge Clk);
        bus.Req       = 1'b1;
        bus.Kind      = KIND_STORE;
        bus.Size      = SZ_BYTE;
        bus.ByteAddr  = 32'h0000_001C;
        bus.StoreData = 32'h0000_00EE;
        @(posedge Clk);
        #1;
        bus.Req = 1'b0;
        chk("rmw_rst_we_access", 32'(bus.MemWe), 32'h0);
        @(posedge Clk);
        #1;
        chk("rmw_rst_we_before", 32'(bus.MemWe), 32'h1);
        chk("rmw_rst_wd_before", bus.MemWd, 32'hEE66_7788);
        Rst_n = 1'b0;
        #1;
        chk("rmw_rst_we_after", 32'(bus.MemWe), 32'h0);
        chk("rmw_rst_busy",     32'(bus.Busy),  32'h0);
        chk("rmw_rst_instr",    bus.Instr,      RST_INSTR);
        chk("rmw_rst_load",     bus.LoadData,   32'h0);
        chk("rmw_rst_faddr",    bus.FaultAddr,  32'h0);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        chk("rmw_rst_mem", mem[7], 32'h5566_7788);

        exp_instr = RST_INSTR;
        exp_load  = 32'h0;
        exp_faddr = 32'h0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  k, s;
            logic        u;
            int unsigned wi, lo;
            logic [31:0] a, d;
            k  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            s  = 2'($urandom_range(0, 2));
            u  = 1'($urandom_range(0, 1));
            wi = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 1000) : $urandom_range(0, 63);
            if ($urandom_range(0, 3) == 0) lo = $urandom_range(0, 3);
            else if (k == KIND_FETCH || s == SZ_WORD) lo = 0;
            else if (s == SZ_HALF) lo = 2 * $urandom_range(0, 1);
            else lo = $urandom_range(0, 3);
            a = 32'(wi * 4 + lo);
            d = $urandom;
            model_req(k, s, u, a, d, ef, el);
            do_req(k, s, u, a, d, lat, gf, wa, w0, w1, a0);
            chk($sformatf("r%0d_lat", n),   32'(lat), 32'(el));
            chk($sformatf("r%0d_fault", n), 32'(gf),  32'(ef));
            chk($sformatf("r%0d_instr", n), bus.Instr, exp_instr);
            chk($sformatf("r%0d_load", n),  bus.LoadData, exp_load);
            chk($sformatf("r%0d_faddr", n), bus.FaultAddr, exp_faddr);
            if (wi < 64) chk($sformatf("r%0d_mem", n), mem[wi], ref_mem[wi]);
            if (ef) chk($sformatf("r%0d_we_any", n), 32'(wa), 32'h0);
        end

        repeat (2) @(posedge Clk);
        chk("done_fault_overlap", 32'(both_seen),    32'h0);
        chk("we_outside_busy",    32'(we_idle_seen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
